// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register for the 5-stage RV32 core: captures ID operands/control,
// pre-decodes the EX operand-mux forwarding selects and handles load-use bubbles.
module id_ex_fwd_reg #(
  parameter int DAT_WIDTH  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  id_valid,
  input  logic [DAT_WIDTH-1:0]  id_pc,
  input  logic [DAT_WIDTH-1:0]  id_rs1_data,
  input  logic [DAT_WIDTH-1:0]  id_rs2_data,
  input  logic [DAT_WIDTH-1:0]  id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_mem_to_reg,
  input  logic [ALU_OP_W-1:0]   id_alu_op,

  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,

  input  logic                  flush_i,
  input  logic                  hold_i,

  output logic                  ex_valid,
  output logic [DAT_WIDTH-1:0]  ex_pc,
  output logic [DAT_WIDTH-1:0]  ex_rs1_data,
  output logic [DAT_WIDTH-1:0]  ex_rs2_data,
  output logic [DAT_WIDTH-1:0]  ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_mem_to_reg,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_o
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic                  valid_q,     valid_d;
  logic [DAT_WIDTH-1:0]  pc_q,        pc_d;
  logic [DAT_WIDTH-1:0]  rs1_data_q,  rs1_data_d;
  logic [DAT_WIDTH-1:0]  rs2_data_q,  rs2_data_d;
  logic [DAT_WIDTH-1:0]  imm_q,       imm_d;
  logic [REG_ADDR_W-1:0] rs1_q,       rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q,       rs2_d;
  logic [REG_ADDR_W-1:0] rd_q,        rd_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_read_q,  mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  alu_src_q,   alu_src_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [ALU_OP_W-1:0]   alu_op_q,    alu_op_d;
  logic [1:0]            fwd_a_q,     fwd_a_d;
  logic [1:0]            fwd_b_q,     fwd_b_d;

  logic load_use;
  logic ex_fwd_ok;
  logic mem_fwd_ok;
  logic bubble;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // A load in EX cannot forward from MEM next cycle; it is caught by load_use instead.
  always_comb begin
    ex_fwd_ok  = valid_q & reg_write_q & ~mem_read_q & (rd_q != '0);
    mem_fwd_ok = mem_valid & mem_reg_write & (mem_rd != '0);

    sel_a = SEL_REG;
    if (ex_fwd_ok && (rd_q == id_rs1))
      sel_a = SEL_MEM;
    else if (mem_fwd_ok && (mem_rd == id_rs1))
      sel_a = SEL_WB;

    sel_b = SEL_REG;
    if (ex_fwd_ok && (rd_q == id_rs2))
      sel_b = SEL_MEM;
    else if (mem_fwd_ok && (mem_rd == id_rs2))
      sel_b = SEL_WB;
  end

  always_comb begin
    load_use = valid_q & mem_read_q & (rd_q != '0) & id_valid &
               ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
    stall_o  = load_use & ~flush_i & ~hold_i;
    bubble   = flush_i | (~hold_i & load_use);
  end

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    alu_src_d    = alu_src_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_op_d     = alu_op_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;

    if (bubble) begin
      valid_d      = 1'b0;
      pc_d         = '0;
      rs1_data_d   = '0;
      rs2_data_d   = '0;
      imm_d        = '0;
      rs1_d        = '0;
      rs2_d        = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      alu_src_d    = 1'b0;
      mem_to_reg_d = 1'b0;
      alu_op_d     = '0;
      fwd_a_d      = SEL_REG;
      fwd_b_d      = SEL_REG;
    end else if (!hold_i) begin
      valid_d      = id_valid;
      pc_d         = id_pc;
      rs1_data_d   = id_rs1_data;
      rs2_data_d   = id_rs2_data;
      imm_d        = id_imm;
      rs1_d        = id_rs1;
      rs2_d        = id_rs2;
      rd_d         = id_rd;
      reg_write_d  = id_reg_write;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      alu_src_d    = id_alu_src;
      mem_to_reg_d = id_mem_to_reg;
      alu_op_d     = id_alu_op;
      fwd_a_d      = sel_a;
      fwd_b_d      = sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_op_q     <= '0;
      fwd_a_q      <= SEL_REG;
      fwd_b_q      <= SEL_REG;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_op_q     <= alu_op_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_alu_op     = alu_op_q;
  assign fwd_a_sel     = fwd_a_q;
  assign fwd_b_sel     = fwd_b_q;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Bench for id_ex_fwd_reg: a table of ID/MEM input vectors with expected stall, action
// and selects; the expected EX contents go through a scoreboard queue checked after each edge.
module tb_id_ex_fwd_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_mem_to_reg;
  logic [3:0]  id_alu_op;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic        flush_i, hold_i;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg;
  logic [3:0]  ex_alu_op;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_o;

  always #5 clk = ~clk;

  id_ex_fwd_reg #(.DAT_WIDTH(32), .REG_ADDR_W(5), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_o(stall_o)
  );

  localparam logic [1:0] A_LOAD = 2'd0;
  localparam logic [1:0] A_BUB  = 2'd1;
  localparam logic [1:0] A_HOLD = 2'd2;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, rw, mr, mw;
    logic       mv, mrw;
    logic [4:0] mrd;
    logic       fl, ho;
    logic       es;
    logic [1:0] act, efa, efb;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, asrc, m2r;
    logic [3:0]  op;
    logic [1:0]  fa, fb;
  } out_t;

  localparam int NV = 25;
  vec_t vec [NV];
  out_t sb_q[$];
  out_t last_exp;
  out_t zero_out;
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic u1, input logic u2,
                              input logic rw, input logic mr, input logic mw,
                              input logic mv, input logic mrw, input logic [4:0] mrd,
                              input logic fl, input logic ho, input logic es,
                              input logic [1:0] act, input logic [1:0] efa, input logic [1:0] efb);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2;
    t.rw = rw; t.mr = mr; t.mw = mw; t.mv = mv; t.mrw = mrw; t.mrd = mrd;
    t.fl = fl; t.ho = ho; t.es = es; t.act = act; t.efa = efa; t.efb = efb;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_out(input out_t e, input int idx);
    chk("ex_valid",      idx, 32'(ex_valid),      32'(e.valid));
    chk("ex_pc",         idx, ex_pc,              e.pc);
    chk("ex_rs1_data",   idx, ex_rs1_data,        e.d1);
    chk("ex_rs2_data",   idx, ex_rs2_data,        e.d2);
    chk("ex_imm",        idx, ex_imm,             e.imm);
    chk("ex_rs1",        idx, 32'(ex_rs1),        32'(e.rs1));
    chk("ex_rs2",        idx, 32'(ex_rs2),        32'(e.rs2));
    chk("ex_rd",         idx, 32'(ex_rd),         32'(e.rd));
    chk("ex_reg_write",  idx, 32'(ex_reg_write),  32'(e.rw));
    chk("ex_mem_read",   idx, 32'(ex_mem_read),   32'(e.mr));
    chk("ex_mem_write",  idx, 32'(ex_mem_write),  32'(e.mw));
    chk("ex_alu_src",    idx, 32'(ex_alu_src),    32'(e.asrc));
    chk("ex_mem_to_reg", idx, 32'(ex_mem_to_reg), 32'(e.m2r));
    chk("ex_alu_op",     idx, 32'(ex_alu_op),     32'(e.op));
    chk("fwd_a_sel",     idx, 32'(fwd_a_sel),     32'(e.fa));
    chk("fwd_b_sel",     idx, 32'(fwd_b_sel),     32'(e.fb));
  endtask

  // ID data fields are derived from the vector index so every load carries distinct data.
  task automatic drive(input vec_t t, input int idx);
    logic [31:0] pc;
    pc = 32'h1000 + 32'(idx) * 32'd4;
    id_valid      = t.v;
    id_pc         = pc;
    id_rs1_data   = {pc[15:0], 16'h1111};
    id_rs2_data   = ~pc;
    id_imm        = pc + 32'h40;
    id_rs1        = t.rs1;
    id_rs2        = t.rs2;
    id_rd         = t.rd;
    id_use_rs1    = t.u1;
    id_use_rs2    = t.u2;
    id_reg_write  = t.rw;
    id_mem_read   = t.mr;
    id_mem_write  = t.mw;
    id_alu_src    = pc[2];
    id_mem_to_reg = t.mr;
    id_alu_op     = t.rd[3:0];
    mem_valid     = t.mv;
    mem_reg_write = t.mrw;
    mem_rd        = t.mrd;
    flush_i       = t.fl;
    hold_i        = t.ho;
  endtask

  function automatic out_t expect_of(input vec_t t, input int idx, input out_t prev);
    out_t e;
    logic [31:0] pc;
    pc = 32'h1000 + 32'(idx) * 32'd4;
    e = '{default: '0};
    if (t.act == A_HOLD) begin
      e = prev;
    end else if (t.act == A_LOAD) begin
      e.valid = t.v;  e.pc = pc;  e.d1 = {pc[15:0], 16'h1111};  e.d2 = ~pc;
      e.imm = pc + 32'h40;  e.rs1 = t.rs1;  e.rs2 = t.rs2;  e.rd = t.rd;
      e.rw = t.rw;  e.mr = t.mr;  e.mw = t.mw;  e.asrc = pc[2];  e.m2r = t.mr;
      e.op = t.rd[3:0];  e.fa = t.efa;  e.fb = t.efb;
    end
    return e;
  endfunction

  task automatic apply(input int idx);
    out_t e;
    @(negedge clk);
    drive(vec[idx], idx);
    #1;
    chk("stall_o", idx, 32'(stall_o), 32'(vec[idx].es));
    e = expect_of(vec[idx], idx, last_exp);
    last_exp = e;
    sb_q.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard vec %0d: got empty queue expected one entry", idx);
    end else begin
      check_out(sb_q.pop_front(), idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        v rs1 rs2 rd u1 u2 rw mr mw mv mrw mrd fl ho es act     fa    fb
    vec[0]  = mk(1, 1, 2, 5, 1,1,1,0,0, 0,0,0,  0,0,0, A_LOAD, 2'd0, 2'd0);
    vec[1]  = mk(1, 5, 6,10, 1,1,1,0,0, 0,0,0,  0,0,0, A_LOAD, 2'd2, 2'd0);
    vec[2]  = mk(1, 1, 2, 8, 1,1,1,0,0, 0,0,0,  0,0,0, A_LOAD, 2'd0, 2'd0);
    vec[3]  = mk(1, 3, 7,11, 1,1,1,0,0, 1,1,7,  0,0,0, A_LOAD, 2'd0, 2'd1);
    vec[4]  = mk(1, 2, 0, 7, 1,0,1,0,1, 1,1,9,  0,0,0, A_LOAD, 2'd0, 2'd0);
    vec[5]  = mk(1, 4, 7,12, 1,1,1,0,0, 1,1,7,  0,0,0, A_LOAD, 2'd0, 2'd2);
    vec[6]  = mk(1, 2, 0, 9, 1,0,1,1,0, 1,1,7,  0,0,0, A_LOAD, 2'd0, 2'd0);
    vec[7]  = mk(1, 9, 4,13, 1,1,1,0,0, 0,0,0,  0,0,1, A_BUB,  2'd0, 2'd0);
    vec[8]  = mk(1, 9, 4,13, 1,1,1,0,0, 1,1,9,  0,0,0, A_LOAD, 2'd1, 2'd0);
    vec[9]  = mk(1, 1, 0, 0, 1,0,1,1,0, 0,0,0,  0,0,0, A_LOAD, 2'd0, 2'd0);
    vec[10] = mk(1, 0, 0,14, 1,1,1,0,0, 1,1,0,  0,0,0, A_LOAD, 2'd0, 2'd0);
    vec[11] = mk(1, 1, 0, 3, 1,0,1,1,0, 0,0,0,  0,0,0, A_LOAD, 2'd0, 2'd0);
    vec[12] = mk(1, 3, 3, 3, 0,0,1,0,0, 0,0,0,  0,0,0, A_LOAD, 2'd0, 2'd0);
    vec[13] = mk(1, 3, 0, 9, 1,0,1,1,0, 0,0,0,  0,0,0, A_LOAD, 2'd2, 2'd0);
    vec[14] = mk(1, 9, 0,15, 1,0,1,0,0, 0,0,0,  1,0,0, A_BUB,  2'd0, 2'd0);
    vec[15] = mk(1, 1, 0, 9, 1,0,1,1,0, 0,0,0,  0,0,0, A_LOAD, 2'd0, 2'd0);
    vec[16] = mk(1, 9, 0,16, 1,0,1,0,0, 0,0,0,  0,1,0, A_HOLD, 2'd0, 2'd0);
    vec[17] = mk(1, 9, 0,16, 1,0,1,0,0, 0,0,0,  0,1,0, A_HOLD, 2'd0, 2'd0);
    vec[18] = mk(1, 9, 0,16, 1,0,1,0,0, 0,0,0,  0,0,1, A_BUB,  2'd0, 2'd0);
    vec[19] = mk(1, 9, 0,16, 1,0,1,0,0, 1,1,9,  0,0,0, A_LOAD, 2'd1, 2'd0);
    vec[20] = mk(1,16, 0,17, 1,0,1,0,0, 0,0,0,  0,0,0, A_LOAD, 2'd2, 2'd0);
    vec[21] = mk(1,17,16,18, 1,1,1,0,0, 1,1,16, 0,1,0, A_HOLD, 2'd0, 2'd0);
    vec[22] = mk(1,17,16,18, 1,1,1,0,0, 1,1,16, 0,1,0, A_HOLD, 2'd0, 2'd0);
    vec[23] = mk(1,17,16,18, 1,1,1,0,0, 1,1,16, 0,1,0, A_HOLD, 2'd0, 2'd0);
    vec[24] = mk(1,17,16,18, 1,1,1,0,0, 1,1,16, 0,0,0, A_LOAD, 2'd2, 2'd1);

    zero_out = '{default: '0};
    last_exp = zero_out;

    rst_n = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,A_LOAD,2'd0,2'd0), 0);
    #12;
    check_out(zero_out, -1);
    chk("stall_o", -1, 32'(stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(i);

    // Asynchronous reset between edges while a valid instruction sits in EX.
    @(negedge clk);
    drive(vec[7], 7);
    rst_n = 1'b0;
    #1;
    n_vec++;
    check_out(zero_out, 100);
    chk("stall_o", 100, 32'(stall_o), 32'd0);
    #1;
    rst_n = 1'b1;
    last_exp = zero_out;
    apply(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/id_ex_fwd_reg.md
Name: id_ex_fwd_reg

Overview:
- ID/EX pipeline register for the 5-stage RV32 pipelined core.
- Captures decoded operands and control from ID and presents them to EX.
- Pre-decodes the 2-bit forwarding selects that drive the EX-stage 3:1 operand muxes one cycle early, so no comparator sits on the EX critical path.
- Detects load-use hazards, inserts a bubble, and requests an upstream stall.

Parameters:
- DAT_WIDTH, 32: width of the data, PC and immediate paths.
- REG_ADDR_W, 5: register index width.
- ALU_OP_W, 4: ALU operation code width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID slot holds a real instruction.
- id_pc  in  DAT_WIDTH  PC of the ID instruction.
- id_rs1_data, id_rs2_data  in  DAT_WIDTH  register-file read data.
- id_imm  in  DAT_WIDTH  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2.
- id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_mem_to_reg  in  1  control bits.
- id_alu_op  in  ALU_OP_W  ALU operation.
- mem_valid, mem_reg_write  in  1  EX/MEM register contents.
- mem_rd  in  REG_ADDR_W  EX/MEM register contents.
- flush_i  in  1  taken branch/jump resolved in EX; squash the ID instruction.
- hold_i  in  1  global pipeline freeze (memory wait).
- ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_mem_to_reg, ex_alu_op  out  matching input widths  registered ID/EX contents.
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects: 00 = register data, 01 = WB result, 10 = MEM ALU result; 11 is never driven.
- stall_o  out  1  hold PC and IF/ID this cycle.

Behaviour:
- Reset: rst_n=0 asynchronously clears every registered output to 0, including the selects (00). stall_o is 0 while in reset.
- Load-use hazard (combinational) is true when all of the following hold:
  - ex_valid & ex_mem_read & ex_rd != 0 & id_valid;
  - (id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd).
- stall_o = load_use & !flush_i & !hold_i.
- Per-edge update priority, highest first:
  1. flush_i: load a bubble.
  2. hold_i: retain all contents, including the selects.
  3. load_use: load a bubble.
  4. Otherwise: load the ID fields and the next selects.
- Bubble definition:
  - ex_valid, ex_reg_write, ex_mem_read and ex_mem_write = 0.
  - fwd selects = 00.
  - All other fields = 0.
- Next-select computation for operand A, using id_rs1 (operand B is identical using id_rs2):
  - 10 if ex_valid & ex_reg_write & !ex_mem_read & ex_rd != 0 & ex_rd == id_rs1. The producer will be in MEM next cycle.
  - else 01 if mem_valid & mem_reg_write & mem_rd != 0 & mem_rd == id_rs1. The producer will be in WB next cycle.
  - else 00.
- Forwarding priority: the younger producer (current EX) beats the older one (current MEM).
- Selects are computed regardless of id_use_rsX; EX ignores B when ex_alu_src=1.
- After a load-use bubble, the stalled instruction re-presents in ID. The load is now in EX/MEM, so the select resolves to 01 (the load writes back from WB). No double stall occurs.
- Writes in WB during the same cycle as the ID read are covered by register-file write-through; this block does not handle them.
- Index x0 never forwards and never stalls.
- flush_i together with load_use: bubble, stall_o=0.
- hold_i together with load_use: contents retained, stall_o=0; the hazard is re-evaluated after release.
- Latency: 1 cycle from ID to EX outputs. stall_o is valid in the same cycle as the hazard.

Test Plan:
- Reset mid-stream: loaded valid instruction, pulse rst_n low between edges -> all outputs 0 immediately, selects 00, stall_o 0.
- EX→EX forward: EX holds add x5 (reg_write=1); ID presents sub with rs1=x5, rs2=x6 -> next cycle fwd_a_sel=10, fwd_b_sel=00, ex_valid=1.
- MEM→EX forward and priority:
  - mem_rd=x7 with reg_write, EX instruction writes x8, ID reads rs2=x7 -> fwd_b_sel=01.
  - Repeat with both EX and MEM writing x7 -> fwd_b_sel=10.
- Load-use: EX is lw x9; ID is add with rs1=x9, use_rs1=1 -> stall_o=1 that cycle, next cycle ex_valid=0 (bubble). On the following edge the add loads with fwd_a_sel=01, stall_o=0.
- x0 and unused source:
  - EX lw x0, ID reads x0 -> stall_o=0, selects 00.
  - EX lw x3, ID is lui with rd=x3 and use_rs1=use_rs2=0 -> no stall.
- Flush/hold interplay:
  - flush_i=1 together with a load-use hazard -> stall_o=0, bubble loaded.
  - hold_i=1 for 3 cycles -> all outputs constant, then normal load on release.
